mole_game_ctrl: RTL and testbench

Game sequencer for the whack-a-mole design. Runs the play state machine, picks pseudo-random mole holes, times mole exposure, judges player presses and keeps the score. Its outputs (`mole_position`, `score`, `guess_correct`, `guess_wrong`) drive `vga_display` directly, replacing the constant tie-offs in the board top.

---
 rtl/mole_pkg.sv | 38 +++
 rtl/mole_lfsr.sv | 34 +++
 rtl/mole_game_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_mole_game_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mole_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mole_pkg
//  Description : Shared constants, state encoding and hole-selection helper
//                for the whack-a-mole game sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package mole_pkg;

    localparam int HOLE_W  = 3;
    localparam int SCORE_W = 8;
    localparam logic [SCORE_W-1:0] SCORE_MAX = 8'd255;

    // Fibonacci taps 8,6,5,4 expressed as a mask over bits [7:0]
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GAP      = 3'd1,
        ST_UP       = 3'd2,
        ST_FEEDBACK = 3'd3,
        ST_OVER     = 3'd4
    } mole_state_e;

    // Take the low LFSR bits as the next hole, stepping one hole on if that
    // would repeat the current hole.
    function automatic logic [HOLE_W-1:0] next_hole(input logic [7:0]        rnd,
                                                    input logic [HOLE_W-1:0] prev);
        logic [HOLE_W-1:0] cand;
        cand = rnd[HOLE_W-1:0];
        if (cand == prev) begin
            cand = cand + 1'b1;
        end
        return cand;
    endfunction

endpackage : mole_pkg
`default_nettype wire

// File: rtl/mole_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : mole_lfsr
//  Description : Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4) with a
//                configurable nonzero seed and asynchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module mole_lfsr
    import mole_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] rnd
);

    logic [7:0] lfsr_q;
    logic       w_fb;

    assign w_fb = ^(lfsr_q & LFSR_TAPS);
    assign rnd  = lfsr_q;

    // Shift every cycle; feedback enters at bit 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= {lfsr_q[6:0], w_fb};
        end
    end

endmodule : mole_lfsr
`default_nettype wire

// File: rtl/mole_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mole_game_ctrl
//  Description : Whack-a-mole game sequencer. Play state machine, random hole
//                selection, mole exposure timing, press judging and score.
//                Optional feature macro: MOLE_LIVES_EN (lives / game over).
//  Revision    : 1.0 - initial release
// ============================================================================
module mole_game_ctrl
    import mole_pkg::*;
#(
    parameter int         MOLE_UP_CYCLES  = 100_000_000,
    parameter int         GAP_CYCLES      = 25_000_000,
    parameter int         FEEDBACK_CYCLES = 50_000_000,
    parameter int         LIVES           = 3,
    parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
    input  logic                master_clk,
    input  logic                rst,
    input  logic                start,
    input  logic                press_valid,
    input  logic [HOLE_W-1:0]   press_pos,
    output logic [HOLE_W-1:0]   mole_position,
    output logic                mole_visible,
    output logic [SCORE_W-1:0]  score,
    output logic                guess_correct,
    output logic                guess_wrong,
    output logic                game_over,
    output logic [1:0]          lives_left
);

    localparam logic [2:0] S_IDLE     = ST_IDLE;
    localparam logic [2:0] S_GAP      = ST_GAP;
    localparam logic [2:0] S_UP       = ST_UP;
    localparam logic [2:0] S_FEEDBACK = ST_FEEDBACK;
    localparam logic [2:0] S_OVER     = ST_OVER;

    localparam int CNT_MAX_A = (MOLE_UP_CYCLES > GAP_CYCLES) ? MOLE_UP_CYCLES : GAP_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > FEEDBACK_CYCLES) ? CNT_MAX_A : FEEDBACK_CYCLES;
    localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    // Counter reload values: a phase of N cycles counts N-1 down to 0
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] UP_LOAD  = CNT_W'(MOLE_UP_CYCLES - 1);
    localparam logic [CNT_W-1:0] FB_LOAD  = CNT_W'(FEEDBACK_CYCLES - 1);
    localparam logic [1:0]       LIVES_INIT = 2'(LIVES);

    logic [2:0]         state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [HOLE_W-1:0]  pos_q,     pos_d;
    logic [SCORE_W-1:0] score_q,   score_d;
    logic               correct_q, correct_d;
    logic               wrong_q,   wrong_d;
    logic [1:0]         lives_q,   lives_d;
    logic [7:0]         w_rnd;
    logic               w_cnt_done;
    logic               w_out_of_lives;

    mole_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (master_clk),
        .rst (rst),
        .rnd (w_rnd)
    );

    assign w_cnt_done = (cnt_q == '0);

`ifdef MOLE_LIVES_EN
    assign w_out_of_lives = (lives_q == 2'd0);
`else
    assign w_out_of_lives = 1'b0;
`endif

    // Next-state logic: one shared down-counter times every phase
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pos_d     = pos_q;
        score_d   = score_q;
        correct_d = correct_q;
        wrong_d   = wrong_q;
        lives_d   = lives_q;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LOAD;
                    score_d = '0;
                    lives_d = LIVES_INIT;
                end
            end

            S_GAP: begin
                if (w_cnt_done) begin
                    pos_d   = next_hole(w_rnd, pos_q);
                    state_d = S_UP;
                    cnt_d   = UP_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_UP: begin
                // A press on the timeout cycle still counts as the press
                if (press_valid || w_cnt_done) begin
                    state_d = S_FEEDBACK;
                    cnt_d   = FB_LOAD;
                    if (press_valid && (press_pos == pos_q)) begin
                        correct_d = 1'b1;
                        if (score_q != SCORE_MAX) begin
                            score_d = score_q + 1'b1;
                        end
                    end else begin
                        wrong_d = 1'b1;
                        if (lives_q != 2'd0) begin
                            lives_d = lives_q - 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_FEEDBACK: begin
                if (w_cnt_done) begin
                    correct_d = 1'b0;
                    wrong_d   = 1'b0;
                    if (w_out_of_lives) begin
                        state_d = S_OVER;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = GAP_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge master_clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pos_q     <= '0;
            score_q   <= '0;
            correct_q <= 1'b0;
            wrong_q   <= 1'b0;
            lives_q   <= LIVES_INIT;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pos_q     <= pos_d;
            score_q   <= score_d;
            correct_q <= correct_d;
            wrong_q   <= wrong_d;
            lives_q   <= lives_d;
        end
    end

    assign mole_position = pos_q;
    assign mole_visible  = (state_q == S_UP);
    assign score         = score_q;
    assign guess_correct = correct_q;
    assign guess_wrong   = wrong_q;

`ifdef MOLE_LIVES_EN
    assign game_over  = (state_q == S_OVER);
    assign lives_left = lives_q;
`else
    // Endless game: lives are tracked internally but never reported
    assign game_over  = 1'b0;
    assign lives_left = LIVES_INIT;

    logic w_unused;
    assign w_unused = ^lives_q;
`endif

endmodule : mole_game_ctrl
`default_nettype wire

// File: tb/tb_mole_game_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mole_game_ctrl
//  Description : Self-checking bench for mole_game_ctrl with a cycle-level
//                behavioural model of the game rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mole_game_ctrl;

    localparam int UP_C    = 10;
    localparam int GAP_C   = 4;
    localparam int FB_C    = 3;
    localparam int LIVES_C = 2;

`ifdef MOLE_LIVES_EN
    localparam bit LIVES_ON = 1'b1;
`else
    localparam bit LIVES_ON = 1'b0;
`endif

    localparam int P_IDLE = 0, P_GAP = 1, P_UP = 2, P_FB = 3, P_OVER = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       press_valid = 1'b0;
    logic [2:0] press_pos = 3'd0;
    logic [2:0] mole_position;
    logic       mole_visible;
    logic [7:0] score;
    logic       guess_correct;
    logic       guess_wrong;
    logic       game_over;
    logic [1:0] lives_left;

    mole_game_ctrl #(
        .MOLE_UP_CYCLES  (UP_C),
        .GAP_CYCLES      (GAP_C),
        .FEEDBACK_CYCLES (FB_C),
        .LIVES           (LIVES_C),
        .LFSR_SEED       (8'hA5)
    ) dut (
        .master_clk    (clk),
        .rst           (rst),
        .start         (start),
        .press_valid   (press_valid),
        .press_pos     (press_pos),
        .mole_position (mole_position),
        .mole_visible  (mole_visible),
        .score         (score),
        .guess_correct (guess_correct),
        .guess_wrong   (guess_wrong),
        .game_over     (game_over),
        .lives_left    (lives_left)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_phase, m_age, m_pos, m_score, m_lives, m_lfsr;
    bit m_gc, m_gw;

    task automatic model_reset();
        m_phase = P_IDLE; m_age = 0; m_pos = 0; m_score = 0;
        m_lives = LIVES_C; m_lfsr = 8'hA5; m_gc = 0; m_gw = 0;
    endtask

    task automatic model_step();
        int cur, np, fb;
        cur = m_lfsr;
        case (m_phase)
            P_IDLE, P_OVER: begin
                if (start) begin
                    m_phase = P_GAP; m_age = 0; m_score = 0; m_lives = LIVES_C;
                end
            end
            P_GAP: begin
                if (m_age == GAP_C - 1) begin
                    np = cur % 8;
                    if (np == m_pos) np = (np + 1) % 8;
                    m_pos = np; m_phase = P_UP; m_age = 0;
                end else m_age++;
            end
            P_UP: begin
                if (press_valid || m_age == UP_C - 1) begin
                    if (press_valid && int'(press_pos) == m_pos) begin
                        m_gc = 1;
                        if (m_score < 255) m_score++;
                    end else begin
                        m_gw = 1;
                        if (LIVES_ON && m_lives > 0) m_lives--;
                    end
                    m_phase = P_FB; m_age = 0;
                end else m_age++;
            end
            default: begin
                if (m_age == FB_C - 1) begin
                    m_gc = 0; m_gw = 0;
                    m_phase = (LIVES_ON && m_lives == 0) ? P_OVER : P_GAP;
                    m_age = 0;
                end else m_age++;
            end
        endcase
        fb = ((cur >> 7) ^ (cur >> 5) ^ (cur >> 4) ^ (cur >> 3)) & 1;
        m_lfsr = ((cur << 1) & 255) | fb;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && !rst) begin
                check("mole_visible",  mole_visible,  (m_phase == P_UP));
                check("mole_position", mole_position, m_pos);
                check("score",         score,         m_score);
                check("guess_correct", guess_correct, m_gc);
                check("guess_wrong",   guess_wrong,   m_gw);
                check("game_over",     game_over,     (LIVES_ON && m_phase == P_OVER));
                check("lives_left",    lives_left,    LIVES_ON ? m_lives : LIVES_C);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input bit s, input bit pv, input logic [2:0] pp);
        start = s; press_valid = pv; press_pos = pp;
        @(negedge clk);
    endtask

    task automatic wait_visible(input int bound, input string name);
        int k;
        k = 0;
        while (!mole_visible && k < bound) begin
            tick(0, 0, 3'd0);
            k++;
        end
        check(name, mole_visible, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int cnt;
    logic [2:0] old_pos;
    bit r_s, r_pv;
    logic [2:0] r_pp;

    initial begin
        // 1: reset, stray presses with no start
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        for (int i = 0; i < 5; i++) tick(0, 1, 3'(i));
        check("idle_visible", mole_visible, 0);
        check("idle_score", score, 0);
        check("idle_lives", lives_left, LIVES_C);

        // 2: start, mole after exactly GAP cycles, correct hit
        tick(1, 1, 3'd0);
        for (int i = 0; i < 3; i++) tick(0, 0, 3'd0);
        check("gap_not_yet_visible", mole_visible, 0);
        tick(0, 0, 3'd0);
        check("gap_then_visible", mole_visible, 1);
        old_pos = mole_position;
        tick(0, 1, 3'(m_pos));
        check("hit_score", score, 1);
        check("hit_correct", guess_correct, 1);
        cnt = 0;
        while (guess_correct && cnt < 10) begin cnt++; tick(0, 0, 3'd0); end
        check("hit_feedback_len", cnt, FB_C);
        wait_visible(10, "second_mole_up");
        check("hole_differs", (mole_position != old_pos), 1);

        // 3: timeout miss
        cnt = 0;
        while (mole_visible && cnt < 20) begin cnt++; tick(0, 0, 3'd0); end
        check("up_timeout_len", cnt, UP_C);
        check("timeout_wrong", guess_wrong, 1);
        check("timeout_score_kept", score, 1);
        check("timeout_lives", lives_left, LIVES_ON ? 1 : LIVES_C);
        cnt = 0;
        while (guess_wrong && cnt < 10) begin cnt++; tick(0, 0, 3'd0); end
        check("miss_feedback_len", cnt, FB_C);

        // 4: correct press on the timeout cycle
        wait_visible(10, "third_mole_up");
        for (int i = 0; i < UP_C - 1; i++) tick(0, 0, 3'd0);
        check("still_up_before_last", mole_visible, 1);
        tick(0, 1, 3'(m_pos));
        check("last_cycle_hit", guess_correct, 1);
        check("last_cycle_not_wrong", guess_wrong, 0);
        check("last_cycle_score", score, 2);

        // 5: game over with lives, saturation otherwise
        if (LIVES_ON) begin
            wait_visible(10, "fourth_mole_up");
            cnt = 0;
            while (!guess_wrong && cnt < 20) begin cnt++; tick(0, 0, 3'd0); end
            check("second_miss_lives", lives_left, 0);
            cnt = 0;
            while (!game_over && cnt < 10) begin cnt++; tick(0, 0, 3'd0); end
            check("game_over_set", game_over, 1);
            tick(1, 0, 3'd0);
            check("restart_score", score, 0);
            check("restart_lives", lives_left, LIVES_C);
            check("restart_not_over", game_over, 0);
            check("restart_in_gap", mole_visible, 0);
        end else begin
            for (int i = 0; i < 258; i++) begin
                wait_visible(12, "sat_mole_up");
                tick(0, 1, 3'(m_pos));
            end
            check("score_saturated", score, 255);
        end

        // random play checked cycle by cycle against the model
        for (int i = 0; i < 500; i++) begin
            r_s  = ($urandom_range(0, 15) == 0);
            r_pv = ($urandom_range(0, 5) == 0);
            r_pp = ($urandom_range(0, 1) == 0) ? 3'(m_pos) : 3'($urandom_range(0, 7));
            tick(r_s, r_pv, r_pp);
        end

        // 6: asynchronous reset mid-UP
        cnt = 0;
        while (!mole_visible && cnt < 60) begin cnt++; tick(1, 0, 3'd0); end
        tick(0, 0, 3'd0);
        check("pre_reset_up", mole_visible, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_visible", mole_visible, 0);
        check("async_rst_score", score, 0);
        check("async_rst_correct", guess_correct, 0);
        check("async_rst_wrong", guess_wrong, 0);
        check("async_rst_over", game_over, 0);
        check("async_rst_pos", mole_position, 0);
        @(negedge clk);
        rst = 1'b0;
        tick(1, 0, 3'd0);
        for (int i = 0; i < 12; i++) tick(0, 0, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mole_game_ctrl
`default_nettype wire
